// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer for the 6502 core.
// Holds the PC, advances it per fetch, redirects on taken branch or jump,
// and squashes wrong-path fetches for FLUSH_CYCLES cycles after a redirect.
// Optional feature macro: PC_SEQ_BRANCH_STATS_EN (saturating taken-branch counter).
module pc_sequencer #(
    parameter int unsigned          PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(16'h0200),
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                stall_in,
    input  logic                halt_in,
    input  logic                branch_taken_in,
    input  logic [PC_WIDTH-1:0] branch_base_in,
    input  logic [7:0]          branch_offset_in,
    input  logic                jump_in,
    input  logic [PC_WIDTH-1:0] jump_target_in,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                fetch_valid_out,
    output logic                flush_out,
    output logic [15:0]         branch_count_out
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned OFF_W = 8;

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    flush_cnt;
    logic [PC_WIDTH-1:0] branch_target;

    // Relative branch target: sign-extended 8-bit offset, carry out discarded.
    assign branch_target = branch_base_in
                         + {{(PC_WIDTH-OFF_W){branch_offset_in[OFF_W-1]}}, branch_offset_in};

    // Sequencer FSM with registered PC, valid and flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= START;
            pc_out          <= RESET_VECTOR;
            fetch_valid_out <= 1'b0;
            flush_out       <= 1'b0;
            flush_cnt       <= '0;
        end else begin
            case (state)
                START: begin
                    state           <= RUN;
                    fetch_valid_out <= 1'b1;
                end
                RUN: begin
                    if (branch_taken_in || jump_in) begin
                        // Branch is the older instruction, so it wins over a jump.
                        pc_out          <= branch_taken_in ? branch_target : jump_target_in;
                        flush_out       <= 1'b1;
                        fetch_valid_out <= 1'b0;
                        flush_cnt       <= CNT_W'(FLUSH_CYCLES - 1);
                        state           <= FLUSH;
                    end else if (halt_in) begin
                        fetch_valid_out <= 1'b0;
                        state           <= HALTED;
                    end else if (!stall_in) begin
                        pc_out <= pc_out + PC_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    // Requests here come from squashed instructions and are ignored.
                    if (flush_cnt == '0) begin
                        flush_out       <= 1'b0;
                        fetch_valid_out <= 1'b1;
                        state           <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                HALTED: begin
                    fetch_valid_out <= 1'b0;
                    flush_out       <= 1'b0;
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

`ifdef PC_SEQ_BRANCH_STATS_EN
    logic branch_accept;

    assign branch_accept = (state == RUN) && branch_taken_in;

    // Saturating count of branch redirects accepted in RUN.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            branch_count_out <= 16'h0000;
        end else if (branch_accept && (branch_count_out != 16'hFFFF)) begin
            branch_count_out <= branch_count_out + 16'd1;
        end
    end
`else
    assign branch_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    typedef struct packed {
        logic [15:0] pc;
        logic        valid;
        logic        flush;
        logic [15:0] cnt;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        halt_in;
    logic        branch_taken_in;
    logic [15:0] branch_base_in;
    logic [7:0]  branch_offset_in;
    logic        jump_in;
    logic [15:0] jump_target_in;
    logic [15:0] pc_out;
    logic        fetch_valid_out;
    logic        flush_out;
    logic [15:0] branch_count_out;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          step_no = 0;
    logic [15:0] exp_cnt = 16'h0000;

    always #5 clk_in = ~clk_in;

    pc_sequencer dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .stall_in         (stall_in),
        .halt_in          (halt_in),
        .branch_taken_in  (branch_taken_in),
        .branch_base_in   (branch_base_in),
        .branch_offset_in (branch_offset_in),
        .jump_in          (jump_in),
        .jump_target_in   (jump_target_in),
        .pc_out           (pc_out),
        .fetch_valid_out  (fetch_valid_out),
        .flush_out        (flush_out),
        .branch_count_out (branch_count_out)
    );

    // Drive one cycle of inputs, queue the expected outputs, then check after the edge.
    task automatic step(input logic rst, input logic br, input logic [15:0] base,
                        input logic [7:0] off, input logic jmp, input logic [15:0] tgt,
                        input logic halt, input logic stall, input logic acc,
                        input logic [15:0] epc, input logic ev, input logic ef);
        exp_t e;
        exp_t got;
        @(negedge clk_in);
        rst_in           = rst;
        branch_taken_in  = br;
        branch_base_in   = base;
        branch_offset_in = off;
        jump_in          = jmp;
        jump_target_in   = tgt;
        halt_in          = halt;
        stall_in         = stall;
`ifdef PC_SEQ_BRANCH_STATS_EN
        if (rst) exp_cnt = 16'h0000;
        else if (acc && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`else
        exp_cnt = 16'h0000;
`endif
        e.pc = epc; e.valid = ev; e.flush = ef; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        step_no++;
        got = sb.pop_front();
        total++;
        assert (pc_out === got.pc) else begin
            bad++;
            $error("FAIL step %0d pc: got %h expected %h", step_no, pc_out, got.pc);
        end
        total++;
        assert (fetch_valid_out === got.valid) else begin
            bad++;
            $error("FAIL step %0d valid: got %b expected %b", step_no, fetch_valid_out, got.valid);
        end
        total++;
        assert (flush_out === got.flush) else begin
            bad++;
            $error("FAIL step %0d flush: got %b expected %b", step_no, flush_out, got.flush);
        end
        total++;
        assert (branch_count_out === got.cnt) else begin
            bad++;
            $error("FAIL step %0d count: got %h expected %h", step_no, branch_count_out, got.cnt);
        end
    endtask

    task automatic idle(input logic [15:0] epc, input logic ev, input logic ef);
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, epc, ev, ef);
    endtask

    task automatic jump(input logic [15:0] tgt);
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, tgt, 1'b0, 1'b0, 1'b0, tgt, 1'b0, 1'b1);
        idle(tgt, 1'b0, 1'b1);
        idle(tgt, 1'b1, 1'b0);
    endtask

    initial begin
        rst_in = 1'b1; stall_in = 1'b0; halt_in = 1'b0; branch_taken_in = 1'b0;
        branch_base_in = '0; branch_offset_in = '0; jump_in = 1'b0; jump_target_in = '0;

        // Reset and release: START then normal advance.
        step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);
        idle(16'h0200, 1'b1, 1'b0);
        idle(16'h0201, 1'b1, 1'b0);
        idle(16'h0202, 1'b1, 1'b0);

        // Move to 0210, then backward branch by -16.
        jump(16'h0210);
        step(1'b0, 1'b1, 16'h0210, 8'hF0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b1);
        idle(16'h0200, 1'b0, 1'b1);
        idle(16'h0200, 1'b1, 1'b0);
        idle(16'h0201, 1'b1, 1'b0);

        // Branch and jump together: branch wins; requests during FLUSH ignored.
        step(1'b0, 1'b1, 16'h1000, 8'h05, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b1, 16'h1005, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h2000, 8'h10, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h1005, 1'b0, 1'b1);
        idle(16'h1005, 1'b1, 1'b0);

        // PC wrap and stall hold.
        jump(16'hFFFF);
        idle(16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Offset extremes with redirect overriding halt and stall.
        step(1'b0, 1'b1, 16'h0005, 8'h80, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'hFF85, 1'b0, 1'b1);
        idle(16'hFF85, 1'b0, 1'b1);
        idle(16'hFF85, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'hFFF0, 8'h7F, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h006F, 1'b0, 1'b1);
        idle(16'h006F, 1'b0, 1'b1);
        idle(16'h006F, 1'b1, 1'b0);

        // Halt with stall at 0300, then requests ignored while halted.
        jump(16'h0300);
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0300, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, i[0], 16'h1234, 8'h11, i[1], 16'h5678, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);

        // Reset out of HALTED.
        step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);
        idle(16'h0200, 1'b1, 1'b0);
        idle(16'h0201, 1'b1, 1'b0);

        // Reset in the middle of a flush window.
        step(1'b0, 1'b1, 16'h0400, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0400, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);
        idle(16'h0200, 1'b1, 1'b0);
        idle(16'h0201, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
